ddr_rd_burst_ctrl: RTL and testbench
====================================

Name: ddr_rd_burst_ctrl

Overview:
- Frame-buffer read master on the DDR side of the display read path.
- Issues AXI4 read bursts over one frame region, only when the downstream async read FIFO has room for the whole burst.
- Pushes each returned 256-bit beat into that FIFO's write port.
- Runs entirely in the FIFO write-clock domain.

Parameters:
ADDR_WIDTH, 28, AXI byte-address width
DATA_WIDTH, 256, beat width; equals FIFO write width
BURST_LEN, 16, max beats per burst (1..256)
FRAME_BASE, 0, byte address of first beat of a frame
FRAME_BEATS, 115200, beats per frame (1280x720x32bit / 256)
FIFO_DEPTH, 512, FIFO write-side depth in beats
WL_WIDTH, 10, FIFO write water-level width (log2(FIFO_DEPTH)+1)

Ports:
wr_clk  in  1  clock (FIFO write clock)
wr_rst  in  1  synchronous reset, active-high
enable  in  1  allow new bursts; level
frame_start  in  1  one-cycle pulse: restart at FRAME_BASE
axi_araddr  out  ADDR_WIDTH  burst start byte address
axi_arlen  out  8  beats-1
axi_arvalid  out  1  address valid
axi_arready  in  1  address accepted
axi_rdata  in  DATA_WIDTH  read data
axi_rvalid  in  1  data valid
axi_rlast  in  1  last beat of burst
axi_rready  out  1  data ready
fifo_wr_en  out  1  FIFO write enable
fifo_wr_data  out  DATA_WIDTH  FIFO write data
fifo_wr_full  in  1  FIFO full
fifo_wr_water_level  in  WL_WIDTH  FIFO write-side fill level
frame_done  out  1  one-cycle pulse after last beat of frame written
busy  out  1  high in ADDR or DATA
err_overflow  out  1  sticky: beat arrived while FIFO full
err_burst  out  1  sticky: rlast position mismatched beat count

Behaviour:
- Reset (wr_rst=1 at wr_clk edge) clears all outputs, counters and flags: state=IDLE, address=FRAME_BASE, remaining=FRAME_BEATS, pending restart cleared.
- Reset mid-burst abandons the burst; the AXI slave/FIFO side is reset by the system at the same time.
- States:
  - IDLE: wait for frame_start, then CHECK.
  - CHECK: compute len=min(BURST_LEN,remaining). Go to ADDR when enable=1 and fifo_wr_water_level + fifo_wr_en + len <= FIFO_DEPTH; fifo_wr_en counts the beat still in the output register. Otherwise stay.
  - ADDR: drive axi_arvalid=1, axi_araddr=address, axi_arlen=len-1; all held stable until axi_arready. On handshake go to DATA; beat counter=0.
  - DATA: axi_rready=1. Each rvalid&rready beat is registered into fifo_wr_data/fifo_wr_en (1-cycle latency) and increments the counter.
    - On beat len: address += len*DATA_WIDTH/8; remaining -= len. Go to DONE if remaining reaches 0, else CHECK.
  - DONE: pulse frame_done once, the cycle after the final fifo_wr_en. Then go to IDLE, reloading address and remaining.
- Burst termination is by beat count only. rlast=1 on a beat other than beat len, or rlast=0 on beat len, sets err_burst; the beat is still written.
- Beat arriving with fifo_wr_full=1: sets err_overflow, beat dropped (fifo_wr_en=0), counting continues.
- frame_start in IDLE/CHECK/DONE: takes effect next cycle; reload address and remaining, go to CHECK. In DONE, frame_done is suppressed.
- frame_start in ADDR/DATA: latched as pending. The current burst completes normally, then reload and go to CHECK. Multiple pulses collapse into one.
- enable=0 only blocks CHECK->ADDR; bursts in flight always complete.
- Address arithmetic wraps modulo 2^ADDR_WIDTH; bursts never cross the frame end because len is clipped.
- busy = (state==ADDR || state==DATA).

Test Plan:
- FRAME_BEATS=40, BURST_LEN=16, FRAME_BASE=0, water_level=0, slave ready immediately -> arlen 15,15,7; araddr 0x000,0x200,0x400; 40 fifo_wr_en pulses, data in order; frame_done pulses once one cycle after the 40th write.
- water_level=500, FIFO_DEPTH=512 -> no arvalid. Drop level to 496 -> burst issued within 2 cycles.
- arready held low 10 cycles -> araddr/arlen/arvalid stable all 10 cycles; no rready before the handshake.
- rlast on beat 8 of a 16-beat burst -> err_burst=1, all 16 beats written, next burst proceeds; err_burst stays 1 until wr_rst.
- fifo_wr_full=1 on beat 3 -> err_overflow=1, 15 writes for the burst.
- frame_start on beat 5 of burst 2 -> burst 2 completes to 16 beats, next araddr=0x000 with arlen=15, no frame_done; wr_rst mid-DATA -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ddr_rd_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ddr_rd_burst_ctrl
//  Purpose  : Frame-buffer AXI4 read master. Issues bursts only when the
//             downstream FIFO can take a whole burst, then streams the beats
//             into the FIFO write port.
//  Revision : 1.0 - initial release
// ============================================================================
module ddr_rd_burst_ctrl #(
    parameter int ADDR_WIDTH  = 28,
    parameter int DATA_WIDTH  = 256,
    parameter int BURST_LEN   = 16,
    parameter int FRAME_BASE  = 0,
    parameter int FRAME_BEATS = 115200,
    parameter int FIFO_DEPTH  = 512,
    parameter int WL_WIDTH    = 10
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  enable,
    input  logic                  frame_start,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic                  axi_rvalid,
    input  logic                  axi_rlast,
    output logic                  axi_rready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_wr_data,
    input  logic                  fifo_wr_full,
    input  logic [WL_WIDTH-1:0]   fifo_wr_water_level,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_overflow,
    output logic                  err_burst
);

    localparam int c_REM_W      = $clog2(FRAME_BEATS + 1);
    localparam int c_BEAT_BYTES = DATA_WIDTH / 8;

    localparam logic [ADDR_WIDTH-1:0] c_FRAME_BASE  = ADDR_WIDTH'(FRAME_BASE);
    localparam logic [c_REM_W-1:0]    c_FRAME_BEATS = c_REM_W'(FRAME_BEATS);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_CHECK = 3'd1;
    localparam logic [2:0] c_S_ADDR  = 3'd2;
    localparam logic [2:0] c_S_DATA  = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [c_REM_W-1:0]    r_remaining;
    logic [8:0]            r_len;
    logic [8:0]            r_beat_cnt;
    logic                  r_pending;
    logic                  r_fifo_wr_en;
    logic [DATA_WIDTH-1:0] r_fifo_wr_data;
    logic                  r_frame_done;
    logic                  r_err_overflow;
    logic                  r_err_burst;

    logic [8:0]            w_len;
    logic [31:0]           w_need;
    logic                  w_room_ok;
    logic                  w_last_beat;
    logic [c_REM_W-1:0]    w_rem_next;
    logic [ADDR_WIDTH-1:0] w_addr_next;

    always_comb begin
        if (32'(r_remaining) < 32'(BURST_LEN)) begin
            w_len = 9'(r_remaining);
        end else begin
            w_len = 9'(BURST_LEN);
        end
        // The beat sitting in the output register is not yet in the level.
        w_need      = 32'(fifo_wr_water_level) + 32'(r_fifo_wr_en) + 32'(w_len);
        w_room_ok   = (w_need <= 32'(FIFO_DEPTH));
        w_last_beat = ((r_beat_cnt + 9'd1) == r_len);
        w_rem_next  = r_remaining - c_REM_W'(r_len);
        w_addr_next = r_addr + ADDR_WIDTH'(32'(r_len) * 32'(c_BEAT_BYTES));
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_state        <= c_S_IDLE;
            r_addr         <= c_FRAME_BASE;
            r_remaining    <= c_FRAME_BEATS;
            r_len          <= 9'd0;
            r_beat_cnt     <= 9'd0;
            r_pending      <= 1'b0;
            r_fifo_wr_en   <= 1'b0;
            r_fifo_wr_data <= '0;
            r_frame_done   <= 1'b0;
            r_err_overflow <= 1'b0;
            r_err_burst    <= 1'b0;
        end else begin
            r_fifo_wr_en <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (frame_start) begin
                        r_addr      <= c_FRAME_BASE;
                        r_remaining <= c_FRAME_BEATS;
                        r_state     <= c_S_CHECK;
                    end
                end
                c_S_CHECK: begin
                    if (frame_start) begin
                        r_addr      <= c_FRAME_BASE;
                        r_remaining <= c_FRAME_BEATS;
                    end else if (enable && w_room_ok) begin
                        r_len   <= w_len;
                        r_state <= c_S_ADDR;
                    end
                end
                c_S_ADDR: begin
                    if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                    if (axi_arready) begin
                        r_beat_cnt <= 9'd0;
                        r_state    <= c_S_DATA;
                    end
                end
                c_S_DATA: begin
                    if (frame_start) begin
                        r_pending <= 1'b1;
                    end
                    if (axi_rvalid) begin
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                        if (axi_rlast != w_last_beat) begin
                            r_err_burst <= 1'b1;
                        end
                        if (fifo_wr_full) begin
                            r_err_overflow <= 1'b1;
                        end else begin
                            r_fifo_wr_en   <= 1'b1;
                            r_fifo_wr_data <= axi_rdata;
                        end
                        // Burst length is decided by beat count alone, never by rlast.
                        if (w_last_beat) begin
                            if (r_pending || frame_start) begin
                                r_pending   <= 1'b0;
                                r_addr      <= c_FRAME_BASE;
                                r_remaining <= c_FRAME_BEATS;
                                r_state     <= c_S_CHECK;
                            end else begin
                                r_addr      <= w_addr_next;
                                r_remaining <= w_rem_next;
                                r_state     <= (w_rem_next == '0) ? c_S_DONE : c_S_CHECK;
                            end
                        end
                    end
                end
                c_S_DONE: begin
                    r_addr      <= c_FRAME_BASE;
                    r_remaining <= c_FRAME_BEATS;
                    if (frame_start) begin
                        r_state <= c_S_CHECK;
                    end else begin
                        r_frame_done <= 1'b1;
                        r_state      <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign axi_arvalid  = (r_state == c_S_ADDR);
    assign axi_araddr   = axi_arvalid ? r_addr : '0;
    assign axi_arlen    = axi_arvalid ? 8'(r_len - 9'd1) : 8'd0;
    assign axi_rready   = (r_state == c_S_DATA);
    assign busy         = axi_arvalid || axi_rready;
    assign fifo_wr_en   = r_fifo_wr_en;
    assign fifo_wr_data = r_fifo_wr_data;
    assign frame_done   = r_frame_done;
    assign err_overflow = r_err_overflow;
    assign err_burst    = r_err_burst;

endmodule
`default_nettype wire

// File: tb/tb_ddr_rd_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ddr_rd_burst_ctrl
//  Purpose  : Self-checking bench: randomized AXI slave timing and data,
//             burst plan and FIFO contents predicted from frame arithmetic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ddr_rd_burst_ctrl;

    localparam int AW    = 28;
    localparam int DW    = 256;
    localparam int BL    = 16;
    localparam int FB    = 40;
    localparam int DEPTH = 512;
    localparam int WLW   = 10;

    logic           wr_clk;
    logic           wr_rst;
    logic           enable;
    logic           frame_start;
    logic [AW-1:0]  axi_araddr;
    logic [7:0]     axi_arlen;
    logic           axi_arvalid;
    logic           axi_arready;
    logic [DW-1:0]  axi_rdata;
    logic           axi_rvalid;
    logic           axi_rlast;
    logic           axi_rready;
    logic           fifo_wr_en;
    logic [DW-1:0]  fifo_wr_data;
    logic           fifo_wr_full;
    logic [WLW-1:0] fifo_wr_water_level;
    logic           frame_done;
    logic           busy;
    logic           err_overflow;
    logic           err_burst;

    ddr_rd_burst_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .FRAME_BASE (0),
        .FRAME_BEATS(FB),
        .FIFO_DEPTH (DEPTH),
        .WL_WIDTH   (WLW)
    ) dut (
        .wr_clk             (wr_clk),
        .wr_rst             (wr_rst),
        .enable             (enable),
        .frame_start        (frame_start),
        .axi_araddr         (axi_araddr),
        .axi_arlen          (axi_arlen),
        .axi_arvalid        (axi_arvalid),
        .axi_arready        (axi_arready),
        .axi_rdata          (axi_rdata),
        .axi_rvalid         (axi_rvalid),
        .axi_rlast          (axi_rlast),
        .axi_rready         (axi_rready),
        .fifo_wr_en         (fifo_wr_en),
        .fifo_wr_data       (fifo_wr_data),
        .fifo_wr_full       (fifo_wr_full),
        .fifo_wr_water_level(fifo_wr_water_level),
        .frame_done         (frame_done),
        .busy               (busy),
        .err_overflow       (err_overflow),
        .err_burst          (err_burst)
    );

    int checks      = 0;
    int errors      = 0;
    int cyc         = 0;
    int wr_cnt      = 0;
    int last_wr_cyc = -100;
    int done_cnt    = 0;
    int done_cyc    = -1;
    logic [DW-1:0] exp_q[$];

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;
    always @(posedge wr_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO-side scoreboard: every write must match the next non-dropped beat.
    always @(negedge wr_clk) begin
        if (fifo_wr_en === 1'b1) begin
            wr_cnt++;
            last_wr_cyc = cyc;
            check("wr_has_expected_beat", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("wr_data", fifo_wr_data, exp_q.pop_front());
            end
        end
        if (frame_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge wr_clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // AXI slave for one burst; beat indices (1-based) select injected events.
    task automatic serve_burst(input logic [AW-1:0] ea, input int elen, input int ar_delay,
                               input int full_at, input int rlast_at, input int restart_at);
        int n;
        logic [DW-1:0] beat;
        n = 0;
        while (axi_arvalid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check("arvalid_seen", axi_arvalid, 1);
        check("araddr", axi_araddr, ea);
        check("arlen", axi_arlen, elen - 1);
        check("rready_before_ar", axi_rready, 0);
        for (int i = 0; i < ar_delay; i++) begin
            tick();
            check("ar_hold_valid", axi_arvalid, 1);
            check("ar_hold_addr", axi_araddr, ea);
            check("ar_hold_len", axi_arlen, elen - 1);
            check("ar_hold_rready", axi_rready, 0);
        end
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        check("rready_in_data", axi_rready, 1);
        check("busy_in_data", busy, 1);
        for (int b = 1; b <= elen; b++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                axi_rdata = rand_beat();
                tick();
            end
            beat         = rand_beat();
            axi_rdata    = beat;
            axi_rvalid   = 1'b1;
            axi_rlast    = (rlast_at > 0) ? (b == rlast_at) : (b == elen);
            fifo_wr_full = (b == full_at);
            frame_start  = (b == restart_at);
            if (b != full_at) exp_q.push_back(beat);
            tick();
            axi_rvalid   = 1'b0;
            axi_rlast    = 1'b0;
            fifo_wr_full = 1'b0;
            frame_start  = 1'b0;
        end
    endtask

    // Burst plan derived from frame arithmetic: fixed-size chunks, last one clipped.
    task automatic run_frame(input int first_delay, input int rlast_burst, input int full_burst);
        int rem;
        int len;
        int k;
        logic [AW-1:0] a;
        rem = FB;
        a   = '0;
        k   = 0;
        while (rem > 0) begin
            len = (rem < BL) ? rem : BL;
            serve_burst(a, len, (k == 0) ? first_delay : int'($urandom_range(0, 3)),
                        (k == full_burst) ? 3 : 0, (k == rlast_burst) ? 8 : 0, 0);
            a   = a + AW'(len * DW / 8);
            rem = rem - len;
            k++;
        end
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        int base_wr;
        int base_done;
        int n;
        wr_rst              = 1'b1;
        enable              = 1'b1;
        frame_start         = 1'b1;
        axi_arready         = 1'b0;
        axi_rdata           = '0;
        axi_rvalid          = 1'b0;
        axi_rlast           = 1'b0;
        fifo_wr_full        = 1'b0;
        fifo_wr_water_level = '0;
        repeat (3) tick();

        check("rst_araddr", axi_araddr, 0);
        check("rst_arlen", axi_arlen, 0);
        check("rst_arvalid", axi_arvalid, 0);
        check("rst_rready", axi_rready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_busy", busy, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_burst", err_burst, 0);

        wr_rst      = 1'b0;
        frame_start = 1'b0;
        repeat (5) tick();
        check("idle_no_arvalid", axi_arvalid, 0);

        // Frame 1: clean frame, first address phase stalled for 10 cycles.
        pulse_start();
        run_frame(10, -1, -1);
        repeat (4) tick();
        check("f1_writes", wr_cnt, FB);
        check("f1_done_count", done_cnt, 1);
        check("f1_done_timing", done_cyc, last_wr_cyc + 1);
        check("f1_queue_drained", exp_q.size(), 0);
        check("f1_err_burst", err_burst, 0);
        check("f1_err_overflow", err_overflow, 0);
        check("f1_busy_after", busy, 0);

        // Frame 2: insufficient FIFO room holds off the burst.
        base_wr             = wr_cnt;
        base_done           = done_cnt;
        fifo_wr_water_level = WLW'($urandom_range(DEPTH - BL + 1, DEPTH));
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            tick();
            check("room_blocked", axi_arvalid, 0);
        end
        fifo_wr_water_level = WLW'($urandom_range(0, DEPTH - BL));
        n = 0;
        while (axi_arvalid !== 1'b1 && n < 2) begin
            tick();
            n++;
        end
        check("room_ok_issue", axi_arvalid, 1);
        run_frame(int'($urandom_range(0, 3)), 0, 1);
        repeat (4) tick();
        check("f2_writes", wr_cnt - base_wr, FB - 1);
        check("f2_done_count", done_cnt - base_done, 1);
        check("f2_done_timing", done_cyc, last_wr_cyc + 1);
        check("f2_err_burst", err_burst, 1);
        check("f2_err_overflow", err_overflow, 1);
        check("f2_queue_drained", exp_q.size(), 0);

        // Frame 3: restart requested mid-burst; burst completes, frame restarts.
        base_wr   = wr_cnt;
        base_done = done_cnt;
        pulse_start();
        serve_burst('0, BL, int'($urandom_range(0, 3)), 0, 0, 0);
        serve_burst(AW'(BL * DW / 8), BL, int'($urandom_range(0, 3)), 0, 0, 5);
        serve_burst('0, BL, int'($urandom_range(0, 3)), 0, 0, 0);
        check("restart_no_done", done_cnt - base_done, 0);
        serve_burst(AW'(BL * DW / 8), BL, int'($urandom_range(0, 3)), 0, 0, 0);
        serve_burst(AW'(2 * BL * DW / 8), FB - 2 * BL, int'($urandom_range(0, 3)), 0, 0, 0);
        repeat (4) tick();
        check("f3_writes", wr_cnt - base_wr, 2 * BL + FB);
        check("f3_done_count", done_cnt - base_done, 1);
        check("f3_err_burst_sticky", err_burst, 1);

        // enable gating, then reset in the middle of a data phase.
        enable              = 1'b0;
        fifo_wr_water_level = '0;
        pulse_start();
        repeat (6) tick();
        check("enable_blocks", axi_arvalid, 0);
        check("enable_idle_busy", busy, 0);
        enable = 1'b1;
        n = 0;
        while (axi_arvalid !== 1'b1 && n < 2) begin
            tick();
            n++;
        end
        check("enable_issue", axi_arvalid, 1);
        check("enable_araddr", axi_araddr, 0);
        axi_arready = 1'b1;
        tick();
        axi_arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            axi_rdata  = rand_beat();
            axi_rvalid = 1'b1;
            exp_q.push_back(axi_rdata);
            tick();
        end
        axi_rvalid = 1'b0;
        wr_rst     = 1'b1;
        tick();
        check("midrst_arvalid", axi_arvalid, 0);
        check("midrst_rready", axi_rready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wr_en", fifo_wr_en, 0);
        check("midrst_wr_data", fifo_wr_data, 0);
        check("midrst_err_burst", err_burst, 0);
        check("midrst_err_overflow", err_overflow, 0);
        check("midrst_frame_done", frame_done, 0);
        wr_rst = 1'b0;
        repeat (4) tick();
        check("post_rst_idle", axi_arvalid, 0);
        check("post_rst_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
